// File: rtl/pkg_cpu_typedefs.sv
// Shared op-code and FSM state types for the multiply/divide unit.
package pkg_cpu_typedefs;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_a_signed(input op_e op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/cpu_mdu_div_core.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none, stepped by the parent each CALC cycle.
module cpu_mdu_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  dvd_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor keeps shifted below 2*divisor, so diff's top bit is a clean borrow
    assign q_bit   = ~diff[DATA_WIDTH];
    assign rem_out = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/cpu_mdu.sv
// RV32M-style multiply/divide unit; CPU_MDU_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: DATA_WIDTH+1 cycles iterative, 1 cycle for divide-by-zero, overflow and fast multiply.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module cpu_mdu
    import pkg_cpu_typedefs::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [2:0]            op_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z_flag
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_e         state_q, state_d;
    op_e            op_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   dvsr_q;
    logic           neg_res_q, neg_rem_q;
    logic [W-1:0]   res_q;

    op_e            op_in;
    logic           accept;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic           div_zero, div_ovf, fast_mul, early;
    logic [W-1:0]   early_res;

    assign op_in  = op_e'(op_sel);
    assign accept = in_valid && in_ready;

    // Both multiply and divide iterate on magnitudes and fix the sign at the end
    assign a_neg = op_a_signed(op_in) && in_a[W-1];
    assign b_neg = op_b_signed(op_in) && in_b[W-1];
    assign a_mag = a_neg ? -in_a : in_a;
    assign b_mag = b_neg ? -in_b : in_b;

    assign div_zero = op_is_div(op_in) && (in_b == '0);
    assign div_ovf  = ((op_in == DIV) || (op_in == REM)) && (in_a == MIN_VAL) && (in_b == '1);

`ifdef CPU_MDU_FAST_MUL_EN
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W-1:0] fast_prod;

    assign fast_a    = $signed({a_neg, in_a});
    assign fast_b    = $signed({b_neg, in_b});
    assign fast_prod = (2*W)'(fast_a) * (2*W)'(fast_b);
    assign fast_mul  = !op_is_div(op_in);
`else
    assign fast_mul  = 1'b0;
`endif

    assign early = div_zero || div_ovf || fast_mul;

    always_comb begin
        early_res = '0;
        if (div_zero) begin
            early_res = ((op_in == DIV) || (op_in == DIVU)) ? '1 : in_a;
        end else if (div_ovf) begin
            early_res = (op_in == DIV) ? MIN_VAL : '0;
        end
`ifdef CPU_MDU_FAST_MUL_EN
        else if (fast_mul) begin
            early_res = (op_in == MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
        end
`endif
    end

    // acc_q holds {product hi, multiplier} or {partial remainder, dividend/quotient}
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nxt, div_nxt, acc_nxt;
    logic [W-1:0]   div_rem;
    logic           div_qbit;

    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[W-1:1]};

    cpu_mdu_div_core #(
        .DATA_WIDTH(W)
    ) u_div_core (
        .rem_in  (acc_q[2*W-1:W]),
        .dvd_bit (acc_q[W-1]),
        .divisor (dvsr_q),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    assign div_nxt = {div_rem, acc_q[W-2:0], div_qbit};
    assign acc_nxt = op_is_div(op_q) ? div_nxt : mul_nxt;

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        prod_fix = neg_res_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_res_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
        rem_fix  = neg_rem_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
        case (op_q)
            MUL:                 final_res = prod_fix[W-1:0];
            MULH, MULHSU, MULHU: final_res = prod_fix[2*W-1:W];
            DIV, DIVU:           final_res = quo_fix;
            default:             final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = early ? DONE : CALC;
            CALC:    if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvsr_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            cnt_q     <= '0;
            acc_q     <= {{W{1'b0}}, op_is_div(op_in) ? a_mag : b_mag};
            dvsr_q    <= op_is_div(op_in) ? b_mag : a_mag;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (early) begin
                res_q <= early_res;
            end
        end else if (state_q == CALC) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                res_q <= final_res;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign z_flag    = (res_q == '0);

endmodule

// File: tb/tb_cpu_mdu.sv
// Directed-vector bench for cpu_mdu at DATA_WIDTH = 32.
module tb_cpu_mdu;
    import pkg_cpu_typedefs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  op_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z_flag;

    int checks = 0;
    int errors = 0;

`ifdef CPU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    cpu_mdu #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count edges from the accept edge until out_valid is seen.
    task automatic start_op(input string tag, input op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_sel   = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        op_sel   = 3'($urandom);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_z_flag"}, {31'b0, z_flag}, {31'b0, (exp == 32'd0)});
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_exit_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_exit_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        start_op(tag, op, a, b, exp, lat);
        finish_op(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        op_sel    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_z_flag", {31'b0, z_flag}, 32'd1);
        rst_n = 1'b1;

        run_op("mul_neg",   MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulhu_max", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhsu",    MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
        run_op("mul_zero",  MUL,    32'h1234_5678, 32'd0,        32'd0,        MUL_LAT);

        run_op("div_neg",   DIV,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, 33);
        run_op("rem_neg",   REM,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33);
        run_op("divu",      DIVU,   32'd100,      32'd7,        32'd14,       33);
        run_op("remu",      REMU,   32'd100,      32'd7,        32'd2,        33);
        run_op("div_negb",  DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_nega",  REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);

        run_op("divu_by0",  DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("remu_by0",  REMU,   32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",   DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",   REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

        // Hold the result under backpressure while new requests are offered
        start_op("bp", MUL, 32'd5, 32'd6, 32'd30, MUL_LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_sel   = DIVU;
            in_a     = $urandom;
            in_b     = 32'd0;
            @(posedge clk);
            #1;
            check("bp_result", result, 32'd30);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        // in_valid stays high through the exit edge; it must not be taken there
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_exit_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_exit_in_ready", {31'b0, in_ready}, 32'd1);

        // Abort mid-CALC with a single reset edge
        @(negedge clk);
        in_valid = 1'b1;
        op_sel   = MUL;
        in_a     = 32'd9;
        in_b     = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
